acc_core_p: RTL and testbench

ACC_CORE_P -- requirements
Module: acc_core_p

---
 rtl/acc_core_p.sv | 204 ++++++++++++++++++++
 tb/tb_acc_core_p.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_core_p.sv
// Accumulator CPU core: fetch/decode/execute sequencer, ALU, data memory, optional return stack.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC); IN/OUT add handshake wait states.
// Backpressure: stalls indefinitely in IN_WAIT, OUT_RDY and OUT_ACK until the device responds.
//
// Ports:
//   g_clk, g_clr        clock, asynchronous active-low reset
//   instr_addr/data     instruction fetch; data returns one cycle after the address
//   input_bus, in_dev_hs, in_dev_ack             input device handshake
//   output_bus, out_dev_hs, out_dev_vld, out_dev_ack  output device handshake
//   pc_output, acc_reg_out, C, V, Z, stk_err     architectural state visibility
// Optional feature: define ACC_CORE_CALL_EN to enable the CALL/RET return stack.
module acc_core_p #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int DA = 3,
  parameter int SD = 4
) (
  input  logic          g_clk,
  input  logic          g_clr,
  output logic [AW-1:0] instr_addr,
  input  logic [DW+3:0] instr_data,
  input  logic [DW-1:0] input_bus,
  input  logic          in_dev_hs,
  output logic          in_dev_ack,
  input  logic          out_dev_hs,
  output logic          out_dev_vld,
  input  logic          out_dev_ack,
  output logic [DW-1:0] output_bus,
  output logic [AW-1:0] pc_output,
  output logic [DW-1:0] acc_reg_out,
  output logic          C,
  output logic          V,
  output logic          Z,
  output logic          stk_err
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, IN_WAIT, OUT_RDY, OUT_ACK} state_t;

  localparam int MW = 1 << DA;
  localparam logic [DW-1:0] DW_V = DW[DW-1:0];

  localparam logic [3:0] OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3, OP_ADD = 4'h4,
                         OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_SHL = 4'h8,
                         OP_SHR = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB, OP_CALL = 4'hC,
                         OP_RET = 4'hD, OP_IN  = 4'hE, OP_OUT = 4'hF;

  state_t        state;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic [DW+3:0] ir;
  logic [DW-1:0] dmem [MW];

  logic [3:0]    op;
  logic [DW-1:0] imm;
  logic [DW-1:0] m;
  logic [DW-1:0] sh;
  logic [DW:0]   sum_w;
  logic [DW:0]   dif_w;
  logic [DW:0]   shl_w;
  logic [DW:0]   shr_w;

  assign op          = ir[DW+3:DW];
  assign imm         = ir[DW-1:0];
  assign instr_addr  = pc;
  assign pc_output   = pc;
  assign acc_reg_out = acc;
  // Ack is combinational so it is high in exactly the cycle the data is taken.
  assign in_dev_ack  = (state == IN_WAIT) && in_dev_hs;

  // Shifts are done one bit wider so the last bit shifted out lands in the
  // extra bit; a shift of zero leaves that bit clear, giving C=0.
  always_comb begin
    m     = dmem[imm[DA-1:0]];
    sum_w = {1'b0, acc} + {1'b0, m};
    dif_w = {1'b0, acc} + {1'b0, ~m} + {{DW{1'b0}}, 1'b1};
    sh    = imm % DW_V;
    shl_w = {1'b0, acc} << sh;
    shr_w = {acc, 1'b0} >> sh;
  end

`ifdef ACC_CORE_CALL_EN
  localparam int SPW = $clog2(SD + 1);
  localparam int SIW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [SPW-1:0] SD_V = SD[SPW-1:0];

  logic [AW-1:0]  stk [SD];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_dec;
  logic [SIW-1:0] wr_idx;
  logic [SIW-1:0] rd_idx;

  always_comb begin
    sp_dec = sp - SPW'(1);
    wr_idx = sp[SIW-1:0];
    rd_idx = sp_dec[SIW-1:0];
  end
`else
  logic unused_sd;
  assign unused_sd = (SD > 0);
  assign stk_err   = 1'b0;
`endif

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state       <= FETCH;
      pc          <= '0;
      acc         <= '0;
      ir          <= '0;
      C           <= 1'b0;
      V           <= 1'b0;
      Z           <= 1'b0;
      output_bus  <= '0;
      out_dev_vld <= 1'b0;
      for (int i = 0; i < MW; i++) dmem[i] <= '0;
`ifdef ACC_CORE_CALL_EN
      sp      <= '0;
      stk_err <= 1'b0;
      for (int i = 0; i < SD; i++) stk[i] <= '0;
`endif
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= instr_data;
          pc    <= pc + AW'(1);
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (op)
            OP_LDI: begin acc <= imm; Z <= (imm == '0); end
            OP_LD:  begin acc <= m;   Z <= (m == '0);   end
            OP_ST:  dmem[imm[DA-1:0]] <= acc;
            OP_ADD: begin
              acc <= sum_w[DW-1:0];
              C   <= sum_w[DW];
              V   <= (acc[DW-1] == m[DW-1]) && (sum_w[DW-1] != acc[DW-1]);
              Z   <= (sum_w[DW-1:0] == '0);
            end
            OP_SUB: begin
              acc <= dif_w[DW-1:0];
              C   <= dif_w[DW];
              V   <= (acc[DW-1] != m[DW-1]) && (dif_w[DW-1] != acc[DW-1]);
              Z   <= (dif_w[DW-1:0] == '0);
            end
            OP_AND: begin acc <= acc & m; C <= 1'b0; V <= 1'b0; Z <= ((acc & m) == '0); end
            OP_OR:  begin acc <= acc | m; C <= 1'b0; V <= 1'b0; Z <= ((acc | m) == '0); end
            OP_SHL: begin
              acc <= shl_w[DW-1:0];
              C   <= shl_w[DW];
              V   <= 1'b0;
              Z   <= (shl_w[DW-1:0] == '0);
            end
            OP_SHR: begin
              acc <= shr_w[DW:1];
              C   <= shr_w[0];
              V   <= 1'b0;
              Z   <= (shr_w[DW:1] == '0);
            end
            OP_JMP: pc <= imm[AW-1:0];
            // Z here is still the value left by the previous instruction.
            OP_JZ:  if (Z) pc <= imm[AW-1:0];
`ifdef ACC_CORE_CALL_EN
            OP_CALL: begin
              if (sp == SD_V) stk_err <= 1'b1;
              else begin
                stk[wr_idx] <= pc;
                sp          <= sp + SPW'(1);
                pc          <= imm[AW-1:0];
              end
            end
            OP_RET: begin
              if (sp == '0) stk_err <= 1'b1;
              else begin
                pc <= stk[rd_idx];
                sp <= sp_dec;
              end
            end
`endif
            OP_IN:  state <= IN_WAIT;
            OP_OUT: state <= OUT_RDY;
            default: ;
          endcase
        end
        IN_WAIT: if (in_dev_hs) begin
          acc   <= input_bus;
          Z     <= (input_bus == '0);
          state <= FETCH;
        end
        OUT_RDY: if (out_dev_hs) begin
          output_bus  <= acc;
          out_dev_vld <= 1'b1;
          state       <= OUT_ACK;
        end
        OUT_ACK: if (out_dev_ack) begin
          out_dev_vld <= 1'b0;
          state       <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_core_p.sv
module tb_acc_core_p;

  localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, LD = 4'h2, ST = 4'h3, ADD = 4'h4,
                         SUB = 4'h5, AND = 4'h6, OR = 4'h7, SHL = 4'h8, SHR = 4'h9,
                         JMP = 4'hA, JZ = 4'hB, CALL = 4'hC, RET = 4'hD, IN = 4'hE, OUT = 4'hF;

  logic        g_clk = 1'b0;
  logic        g_clr = 1'b1;
  logic [7:0]  instr_addr;
  logic [11:0] instr_data = '0;
  logic [7:0]  input_bus = '0;
  logic        in_dev_hs = 1'b0;
  logic        in_dev_ack;
  logic        out_dev_hs = 1'b0;
  logic        out_dev_vld;
  logic        out_dev_ack = 1'b0;
  logic [7:0]  output_bus;
  logic [7:0]  pc_output;
  logic [7:0]  acc_reg_out;
  logic        C, V, Z, stk_err;

  logic [11:0] imem [256];
  int nvec = 0;
  int nerr = 0;

  acc_core_p #(.DW(8), .AW(8), .DA(3), .SD(4)) dut (
    .g_clk(g_clk), .g_clr(g_clr), .instr_addr(instr_addr), .instr_data(instr_data),
    .input_bus(input_bus), .in_dev_hs(in_dev_hs), .in_dev_ack(in_dev_ack),
    .out_dev_hs(out_dev_hs), .out_dev_vld(out_dev_vld), .out_dev_ack(out_dev_ack),
    .output_bus(output_bus), .pc_output(pc_output), .acc_reg_out(acc_reg_out),
    .C(C), .V(V), .Z(Z), .stk_err(stk_err)
  );

  always #5 g_clk = ~g_clk;

  // Synchronous instruction ROM: data appears one cycle after the address.
  always @(posedge g_clk) instr_data <= imem[instr_addr];

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  task automatic clear_imem;
    for (int i = 0; i < 256; i++) imem[i] = 12'h000;
  endtask

  task automatic step;
    @(negedge g_clk);
    #1;
  endtask

  task automatic do_reset;
    g_clr = 1'b0; in_dev_hs = 1'b0; out_dev_hs = 1'b0; out_dev_ack = 1'b0; input_bus = '0;
    step();
    g_clr = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (3 * n) step();
  endtask

  task automatic test_reset;
    g_clr = 1'b0;
    #1;
    nvec++; if (pc_output !== 8'h00) begin nerr++; $display("FAIL rst_pc: got %h want 00", pc_output); end
    nvec++; if (acc_reg_out !== 8'h00) begin nerr++; $display("FAIL rst_acc: got %h want 00", acc_reg_out); end
    nvec++; if ({C, V, Z, stk_err} !== 4'b0000) begin nerr++; $display("FAIL rst_flags: got %b want 0000", {C, V, Z, stk_err}); end
    nvec++; if ({out_dev_vld, in_dev_ack} !== 2'b00) begin nerr++; $display("FAIL rst_hs: got %b want 00", {out_dev_vld, in_dev_ack}); end
    nvec++; if (output_bus !== 8'h00) begin nerr++; $display("FAIL rst_obus: got %h want 00", output_bus); end
    nvec++; if (instr_addr !== 8'h00) begin nerr++; $display("FAIL rst_iaddr: got %h want 00", instr_addr); end
    step();
    g_clr = 1'b1;
  endtask

  task automatic test_add_overflow;
    clear_imem();
    imem[0] = ins(LDI, 8'h7F); imem[1] = ins(ST, 8'h02); imem[2] = ins(LDI, 8'h01); imem[3] = ins(ADD, 8'h02);
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      run(1);
      nvec++; if (instr_addr !== 8'(k)) begin nerr++; $display("FAIL add_timing%0d: got %h want %h", k, instr_addr, 8'(k)); end
    end
    nvec++; if (acc_reg_out !== 8'h80) begin nerr++; $display("FAIL add_acc: got %h want 80", acc_reg_out); end
    nvec++; if ({C, V, Z} !== 3'b010) begin nerr++; $display("FAIL add_cvz: got %b want 010", {C, V, Z}); end
  endtask

  task automatic test_sub_jz;
    clear_imem();
    imem[0] = ins(LDI, 8'h05); imem[1] = ins(ST, 8'h01); imem[2] = ins(SUB, 8'h01); imem[3] = ins(JZ, 8'h20);
    imem[8'h20] = ins(LDI, 8'h80); imem[8'h21] = ins(ST, 8'h00); imem[8'h22] = ins(LDI, 8'h00);
    imem[8'h23] = ins(SUB, 8'h00); imem[8'h24] = ins(JZ, 8'h40);
    do_reset();
    run(3);
    nvec++; if (acc_reg_out !== 8'h00) begin nerr++; $display("FAIL sub_acc: got %h want 00", acc_reg_out); end
    nvec++; if ({C, V, Z} !== 3'b101) begin nerr++; $display("FAIL sub_cvz: got %b want 101", {C, V, Z}); end
    run(1);
    nvec++; if (instr_addr !== 8'h20) begin nerr++; $display("FAIL jz_taken: got %h want 20", instr_addr); end
    run(4);
    nvec++; if (acc_reg_out !== 8'h80) begin nerr++; $display("FAIL sub_ovf_acc: got %h want 80", acc_reg_out); end
    nvec++; if ({C, V, Z} !== 3'b010) begin nerr++; $display("FAIL sub_ovf_cvz: got %b want 010", {C, V, Z}); end
    run(1);
    nvec++; if (instr_addr !== 8'h25) begin nerr++; $display("FAIL jz_not_taken: got %h want 25", instr_addr); end
  endtask

  task automatic test_st_ld;
    clear_imem();
    imem[0] = ins(LDI, 8'h5A); imem[1] = ins(ST, 8'h0A); imem[2] = ins(LDI, 8'h00);
    imem[3] = ins(LD, 8'h02); imem[4] = ins(LD, 8'h01); imem[5] = ins(JMP, 8'h80);
    do_reset();
    run(3);
    nvec++; if (Z !== 1'b1) begin nerr++; $display("FAIL ldi_zero_z: got %b want 1", Z); end
    run(1);
    nvec++; if ({acc_reg_out, Z} !== {8'h5A, 1'b0}) begin nerr++; $display("FAIL ld_alias: got %h/%b want 5a/0", acc_reg_out, Z); end
    run(1);
    nvec++; if ({acc_reg_out, Z} !== {8'h00, 1'b1}) begin nerr++; $display("FAIL ld_cleared: got %h/%b want 00/1", acc_reg_out, Z); end
    run(1);
    nvec++; if ({instr_addr, Z} !== {8'h80, 1'b1}) begin nerr++; $display("FAIL jmp: got %h/%b want 80/1", instr_addr, Z); end
  endtask

  task automatic test_logic_shift;
    clear_imem();
    imem[0] = ins(LDI, 8'h81); imem[1] = ins(SHL, 8'h01); imem[2] = ins(SHL, 8'h08);
    imem[3] = ins(SHR, 8'h02); imem[4] = ins(LDI, 8'hF0); imem[5] = ins(ST, 8'h03);
    imem[6] = ins(LDI, 8'h3C); imem[7] = ins(AND, 8'h03); imem[8] = ins(OR, 8'h03); imem[9] = ins(SHL, 8'h0C);
    do_reset();
    run(2);
    nvec++; if ({acc_reg_out, C, V, Z} !== {8'h02, 3'b100}) begin nerr++; $display("FAIL shl1: got %h/%b want 02/100", acc_reg_out, {C, V, Z}); end
    run(1);
    nvec++; if ({acc_reg_out, C, V, Z} !== {8'h02, 3'b000}) begin nerr++; $display("FAIL shl_zero: got %h/%b want 02/000", acc_reg_out, {C, V, Z}); end
    run(1);
    nvec++; if ({acc_reg_out, C, V, Z} !== {8'h00, 3'b101}) begin nerr++; $display("FAIL shr2: got %h/%b want 00/101", acc_reg_out, {C, V, Z}); end
    run(1);
    nvec++; if ({acc_reg_out, C, V, Z} !== {8'hF0, 3'b100}) begin nerr++; $display("FAIL ldi_keeps_c: got %h/%b want f0/100", acc_reg_out, {C, V, Z}); end
    run(3);
    nvec++; if ({acc_reg_out, C, V, Z} !== {8'h30, 3'b000}) begin nerr++; $display("FAIL and: got %h/%b want 30/000", acc_reg_out, {C, V, Z}); end
    run(1);
    nvec++; if ({acc_reg_out, C, V, Z} !== {8'hF0, 3'b000}) begin nerr++; $display("FAIL or: got %h/%b want f0/000", acc_reg_out, {C, V, Z}); end
    run(1);
    nvec++; if ({acc_reg_out, C, V, Z} !== {8'h00, 3'b101}) begin nerr++; $display("FAIL shl_mod: got %h/%b want 00/101", acc_reg_out, {C, V, Z}); end
  endtask

  task automatic test_in_stall;
    clear_imem();
    imem[0] = ins(IN, 8'h00); imem[1] = ins(LDI, 8'h11);
    do_reset();
    run(1);
    for (int i = 0; i < 10; i++) begin
      step();
      nvec++; if ({in_dev_ack, acc_reg_out} !== {1'b0, 8'h00}) begin nerr++; $display("FAIL in_stall%0d: got %b/%h want 0/00", i, in_dev_ack, acc_reg_out); end
    end
    input_bus = 8'hA5; in_dev_hs = 1'b1;
    #1;
    nvec++; if (in_dev_ack !== 1'b1) begin nerr++; $display("FAIL in_ack_hi: got %b want 1", in_dev_ack); end
    step();
    nvec++; if ({in_dev_ack, acc_reg_out, Z} !== {1'b0, 8'hA5, 1'b0}) begin nerr++; $display("FAIL in_taken: got %b/%h/%b want 0/a5/0", in_dev_ack, acc_reg_out, Z); end
    nvec++; if (instr_addr !== 8'h01) begin nerr++; $display("FAIL in_next_fetch: got %h want 01", instr_addr); end
    in_dev_hs = 1'b0; input_bus = 8'h00;
    run(1);
    nvec++; if (acc_reg_out !== 8'h11) begin nerr++; $display("FAIL in_resume: got %h want 11", acc_reg_out); end
  endtask

  task automatic test_out_handshake;
    clear_imem();
    imem[0] = ins(LDI, 8'h3C); imem[1] = ins(OUT, 8'h00); imem[2] = ins(LDI, 8'h00);
    do_reset();
    run(2);
    for (int i = 0; i < 5; i++) begin
      step();
      nvec++; if ({out_dev_vld, output_bus} !== {1'b0, 8'h00}) begin nerr++; $display("FAIL out_wait%0d: got %b/%h want 0/00", i, out_dev_vld, output_bus); end
    end
    out_dev_hs = 1'b1;
    step();
    out_dev_hs = 1'b0;
    nvec++; if ({out_dev_vld, output_bus} !== {1'b1, 8'h3C}) begin nerr++; $display("FAIL out_vld: got %b/%h want 1/3c", out_dev_vld, output_bus); end
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++; if (out_dev_vld !== 1'b1) begin nerr++; $display("FAIL out_hold%0d: got %b want 1", i, out_dev_vld); end
    end
    out_dev_ack = 1'b1;
    step();
    out_dev_ack = 1'b0;
    nvec++; if ({out_dev_vld, instr_addr} !== {1'b0, 8'h02}) begin nerr++; $display("FAIL out_ack: got %b/%h want 0/02", out_dev_vld, instr_addr); end
    run(1);
    nvec++; if ({acc_reg_out, output_bus} !== {8'h00, 8'h3C}) begin nerr++; $display("FAIL out_persist: got %h/%h want 00/3c", acc_reg_out, output_bus); end
  endtask

  task automatic test_reset_mid_out;
    clear_imem();
    imem[0] = ins(LDI, 8'h3C); imem[1] = ins(OUT, 8'h00);
    do_reset();
    run(2);
    out_dev_hs = 1'b1;
    step();
    out_dev_hs = 1'b0;
    nvec++; if (out_dev_vld !== 1'b1) begin nerr++; $display("FAIL mid_pre_vld: got %b want 1", out_dev_vld); end
    g_clr = 1'b0;
    #1;
    nvec++; if ({out_dev_vld, output_bus, acc_reg_out} !== {1'b0, 8'h00, 8'h00}) begin nerr++; $display("FAIL mid_async: got %b/%h/%h want 0/00/00", out_dev_vld, output_bus, acc_reg_out); end
    step();
    g_clr = 1'b1;
    nvec++; if (instr_addr !== 8'h00) begin nerr++; $display("FAIL mid_fetch0: got %h want 00", instr_addr); end
    run(1);
    nvec++; if ({acc_reg_out, instr_addr} !== {8'h3C, 8'h01}) begin nerr++; $display("FAIL mid_restart: got %h/%h want 3c/01", acc_reg_out, instr_addr); end
  endtask

`ifdef ACC_CORE_CALL_EN
  task automatic test_call_ret;
    logic [7:0] exp_pc [10] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h41, 8'h31, 8'h21, 8'h11, 8'h01, 8'h02};
    logic       exp_er [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    clear_imem();
    imem[8'h00] = ins(CALL, 8'h10); imem[8'h10] = ins(CALL, 8'h20); imem[8'h20] = ins(CALL, 8'h30);
    imem[8'h30] = ins(CALL, 8'h40); imem[8'h40] = ins(CALL, 8'h50); imem[8'h41] = ins(RET, 8'h00);
    imem[8'h31] = ins(RET, 8'h00); imem[8'h21] = ins(RET, 8'h00); imem[8'h11] = ins(RET, 8'h00);
    imem[8'h01] = ins(RET, 8'h00);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      run(1);
      nvec++; if ({instr_addr, stk_err} !== {exp_pc[k], exp_er[k]}) begin nerr++; $display("FAIL call_ret%0d: got %h/%b want %h/%b", k, instr_addr, stk_err, exp_pc[k], exp_er[k]); end
    end
  endtask
`else
  task automatic test_call_ret;
    clear_imem();
    imem[0] = ins(LDI, 8'h00); imem[1] = ins(CALL, 8'h10); imem[2] = ins(RET, 8'h00);
    do_reset();
    run(2);
    nvec++; if ({instr_addr, stk_err, Z} !== {8'h02, 1'b0, 1'b1}) begin nerr++; $display("FAIL call_nop: got %h/%b/%b want 02/0/1", instr_addr, stk_err, Z); end
    run(1);
    nvec++; if ({instr_addr, stk_err, Z} !== {8'h03, 1'b0, 1'b1}) begin nerr++; $display("FAIL ret_nop: got %h/%b/%b want 03/0/1", instr_addr, stk_err, Z); end
  endtask
`endif

  initial begin
    clear_imem();
    step();
    test_reset();
    test_add_overflow();
    test_sub_jz();
    test_st_ld();
    test_logic_shift();
    test_in_stall();
    test_out_handshake();
    test_reset_mid_out();
    test_call_ret();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
